// File: rtl/d_latch_pkg.sv
// Shared constants for the level-sensitive D latch slice.
// Optional feature macro used by the top: DLATCH_QN_EN (adds the Qn output).
`timescale 1ns/100ps
package d_latch_pkg;

  localparam int unsigned D_LATCH_DEFAULT_WIDTH = 1;
  localparam logic        D_LATCH_RST_VAL       = 1'b0;

  // Complement of the reset value, used for the optional inverted output.
  function automatic logic d_latch_rst_val_n();
    return ~D_LATCH_RST_VAL;
  endfunction

endpackage : d_latch_pkg

// File: rtl/d_latch_cell.sv
// Single-bit level-sensitive D latch with a gate-qualified reset.
// Transparent while clk is high, holds while clk is low.
`timescale 1ns/100ps
module d_latch_cell
  import d_latch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  // Open while the gate is high; reset only acts during the open phase.
  always_latch begin
    if (clk) begin
      if (rst) begin
        q <= D_LATCH_RST_VAL;
      end else begin
        q <= d;
      end
    end
  end

endmodule : d_latch_cell

// File: rtl/d_latch_single.sv
// WIDTH-bit level-sensitive D latch built from independent 1-bit cells.
// Define DLATCH_QN_EN to add the complemented output Qn.
`timescale 1ns/100ps
module d_latch_single
  import d_latch_pkg::*;
#(
  parameter int unsigned WIDTH = D_LATCH_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] Q
`ifdef DLATCH_QN_EN
  ,
  output logic [WIDTH-1:0] Qn
`endif
);

  // One independent cell per bit; no cross-bit logic.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    d_latch_cell u_cell (
      .clk (clk),
      .rst (rst),
      .d   (in[i]),
      .q   (Q[i])
    );
  end

`ifdef DLATCH_QN_EN
  // Inverted output tracks Q, so it reads all ones under reset and holds with Q.
  assign Qn = ~Q;
`else
  // Without the option there is no inverted output and no extra logic.
`endif

endmodule : d_latch_single

// File: tb/tb_d_latch_single.sv
// Directed bench for d_latch_single (WIDTH=1 and WIDTH=8 instances).
// Qn checks are active when DLATCH_QN_EN is defined.
`timescale 1ns/100ps
module tb_d_latch_single;

  logic       clk;
  logic       rst;
  logic       in1;
  logic [7:0] in8;
  logic       q1;
  logic [7:0] q8;
`ifdef DLATCH_QN_EN
  logic       qn1;
  logic [7:0] qn8;
`endif

  int checks;
  int errors;

  d_latch_single #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .in  (in1),
    .Q   (q1)
`ifdef DLATCH_QN_EN
    ,
    .Qn  (qn1)
`endif
  );

  d_latch_single #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .in  (in8),
    .Q   (q8)
`ifdef DLATCH_QN_EN
    ,
    .Qn  (qn8)
`endif
  );

  // 10 ns period, starting low: rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: while the gate is open, the stored value is the input
  // (or zero under reset); while closed, it keeps whatever it last stored.
  logic       mdl_valid;
  logic       mdl_q1;
  logic [7:0] mdl_q8;

  initial begin
    mdl_valid = 1'b0;
    mdl_q1    = 1'b0;
    mdl_q8    = 8'h00;
  end

  // Compare process: re-evaluates the model and checks 0.1 ns after any change.
  always @(clk or rst or in1 or in8) begin
    #0.1;
    if (clk) begin
      mdl_valid = 1'b1;
      mdl_q1    = rst ? 1'b0 : in1;
      mdl_q8    = rst ? 8'h00 : in8;
    end
    if (mdl_valid) begin
      check("model_q1", 8'(q1), 8'(mdl_q1));
      check("model_q8", q8, mdl_q8);
`ifdef DLATCH_QN_EN
      check("model_qn1", 8'(qn1), 8'(~mdl_q1));
      check("model_qn8", qn8, ~mdl_q8);
`endif
    end
  end

  // Directed stimulus with hand-computed expectations at absolute times.
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in1 = 1'b1;
    in8 = 8'h00;

    // Reset while transparent (gate opens at 5).
    #7;   check("rst_open_q1", 8'(q1), 8'h00);
          check("rst_open_q8", q8, 8'h00);
`ifdef DLATCH_QN_EN
          check("rst_open_qn1", 8'(qn1), 8'h01);
`endif
    #4;   rst = 1'b0;                          // t=11, gate closed
    #1;   in1 = 1'b1;                          // t=12
          check("hold_after_rst", 8'(q1), 8'h00);
    // Follow while transparent (gate open 15..20).
    #3.5; check("follow_1", 8'(q1), 8'h01);    // t=15.5
    #0.5; in1 = 1'b0;                          // t=16
    #0.5; check("follow_0", 8'(q1), 8'h00);
    #2.5; in1 = 1'b1;                          // t=19
    #0.5; check("follow_1b", 8'(q1), 8'h01);
    // Hold while closed (20..25), input toggling.
    #1.5; in1 = 1'b0;                          // t=21
    #2;   in1 = 1'b1;                          // t=23
    #1;   in1 = 1'b0;                          // t=24
    #0.5; check("hold_q1", 8'(q1), 8'h01);     // t=24.5
    #1;   check("reopen_q1", 8'(q1), 8'h00);   // t=25.5
    #0.5; in1 = 1'b1;                          // t=26
    // Reset pulse entirely inside the closed phase (30..35).
    #5;   rst = 1'b1;                          // t=31
    #3;   rst = 1'b0;                          // t=34
    #0.5; check("rst_pulse_hold", 8'(q1), 8'h01);
    #1;   check("after_pulse", 8'(q1), 8'h01); // t=35.5
    // Reset still high at the rising edge (closed 40..45).
    #5.5; rst = 1'b1;                          // t=41
    #3;   check("rst_low_hold", 8'(q1), 8'h01);// t=44
    #1.5; check("rst_at_rise", 8'(q1), 8'h00); // t=45.5
    #1.5; rst = 1'b0;                          // t=47
    #0.5; check("rst_release", 8'(q1), 8'h01);
    #0.5; rst = 1'b1;                          // t=48
    #0.5; check("rst_mid_open", 8'(q1), 8'h00);
    #0.5; rst = 1'b0;                          // t=49
    // Eight-bit instance (gate open 55..60).
    #7;   in8 = 8'hA5;                         // t=56
    #0.5; check("w8_follow", q8, 8'hA5);
`ifdef DLATCH_QN_EN
          check("qn_open_q1", 8'(q1), 8'h01);
          check("qn_open_qn1", 8'(qn1), 8'h00);
`endif
    #4.5; in8 = 8'h3C;                         // t=61, closed
    #1;   check("w8_hold", q8, 8'hA5);         // t=62
    #1;   rst = 1'b1;                          // t=63
    #2.5; check("w8_rst_rise", q8, 8'h00);     // t=65.5
`ifdef DLATCH_QN_EN
          check("qn_rst_qn1", 8'(qn1), 8'h01);
          check("qn_rst_qn8", qn8, 8'hFF);
`endif
    #1.5; rst = 1'b0;                          // t=67
    #1;   in8 = 8'hF0;                         // t=68
    #1;   in8 = 8'h0F;                         // t=69
    #0.5; check("w8_follow2", q8, 8'h0F);
    #1.5; in8 = 8'h55;                         // t=71, closed
    #1;   check("w8_hold2", q8, 8'h0F);        // t=72
    #3.5; check("w8_reopen", q8, 8'h55);       // t=75.5
    #4.5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_d_latch_single
